// File: rtl/conv_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_scan_ctrl_pkg
// Brief   : Shared state encoding and output-map sizing for the conv scan.
// Revision: 1.0
// ============================================================================
package conv_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of window positions along one axis (integer division).
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_scan_ctrl_if
// Brief   : Tap stream bundle between the scan controller and the MAC stage.
// Revision: 1.0
// ============================================================================
interface conv_scan_ctrl_if #(
    parameter int CW = 4,
    parameter int AW = 6
);
    logic          start;
    logic          abort;
    logic          ready;
    logic          busy;
    logic          valid;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] addr;
    logic          first_tap;
    logic          last_tap;
    logic          done;

    modport master (
        input  start, abort, ready,
        output busy, valid, row, col, addr, first_tap, last_tap, done
    );

    modport slave (
        output start, abort, ready,
        input  busy, valid, row, col, addr, first_tap, last_tap, done
    );
endinterface
`default_nettype wire

// File: rtl/conv_scan_ctrl_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module  : conv_scan_ctrl_wrap_counter
// Brief   : Up-counter wrapping at MAX; wrap_o chains into the next stage.
// Revision: 1.0
// ============================================================================
module conv_scan_ctrl_wrap_counter #(
    parameter int CW  = 4,
    parameter int MAX = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en_i,
    input  wire logic          clr_i,
    output logic [CW-1:0]      nxt_o,
    output logic               wrap_o
);
    logic [CW-1:0] q_q;
    logic [CW-1:0] q_d;

    // nxt_o exposes the post-edge value so the owner can register derived outputs.
    always_comb begin
        wrap_o = en_i && (q_q == CW'(MAX));
        q_d    = q_q;
        if (clr_i || wrap_o) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = q_q + 1'b1;
        end
    end

    assign nxt_o = q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : conv_scan_ctrl
// Brief   : Walks a KxK window over an IMG_H x IMG_W map, one tap per handshake.
// Revision: 1.0
// ============================================================================
module conv_scan_ctrl
    import conv_scan_ctrl_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int CW     = 4,
    parameter int AW     = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv_scan_ctrl_if.master bus
);
    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

    state_e        state_q;
    logic          busy_q;
    logic          valid_q;
    logic          done_q;
    logic          first_q;
    logic          last_q;
    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;

    logic          w_scan;
    logic          w_xfer;
    logic          w_abort;
    logic          w_step;
    logic          w_kc_wrap;
    logic          w_kr_wrap;
    logic          w_ocol_wrap;
    logic          w_final;
    logic [CW-1:0] w_kc_nxt;
    logic [CW-1:0] w_kr_nxt;
    logic [CW-1:0] w_ocol_nxt;
    logic [CW-1:0] w_orow_nxt;
    logic [CW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;
    logic          w_first_nxt;
    logic          w_last_nxt;

    assign w_scan  = (state_q == S_SCAN);
    assign w_xfer  = w_scan && valid_q && bus.ready;
    assign w_abort = w_scan && bus.abort;
    // An aborted transfer still counts as consumed, but must not move the indices.
    assign w_step  = w_xfer && !w_abort;

    conv_scan_ctrl_wrap_counter #(.CW(CW), .MAX(K - 1)) u_kc (
        .clk(clk), .rst(rst), .en_i(w_step), .clr_i(w_abort),
        .nxt_o(w_kc_nxt), .wrap_o(w_kc_wrap)
    );
    conv_scan_ctrl_wrap_counter #(.CW(CW), .MAX(K - 1)) u_kr (
        .clk(clk), .rst(rst), .en_i(w_kc_wrap), .clr_i(w_abort),
        .nxt_o(w_kr_nxt), .wrap_o(w_kr_wrap)
    );
    conv_scan_ctrl_wrap_counter #(.CW(CW), .MAX(OUT_W - 1)) u_ocol (
        .clk(clk), .rst(rst), .en_i(w_kr_wrap), .clr_i(w_abort),
        .nxt_o(w_ocol_nxt), .wrap_o(w_ocol_wrap)
    );
    conv_scan_ctrl_wrap_counter #(.CW(CW), .MAX(OUT_H - 1)) u_orow (
        .clk(clk), .rst(rst), .en_i(w_ocol_wrap), .clr_i(w_abort),
        .nxt_o(w_orow_nxt), .wrap_o(w_final)
    );

    assign w_row_nxt   = CW'(32'(w_orow_nxt) * 32'(STRIDE) + 32'(w_kr_nxt));
    assign w_col_nxt   = CW'(32'(w_ocol_nxt) * 32'(STRIDE) + 32'(w_kc_nxt));
    assign w_first_nxt = (w_kr_nxt == '0) && (w_kc_nxt == '0);
    assign w_last_nxt  = (w_kr_nxt == CW'(K - 1)) && (w_kc_nxt == CW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_SCAN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        row_q   <= w_row_nxt;
                        col_q   <= w_col_nxt;
                        first_q <= w_first_nxt;
                        last_q  <= w_last_nxt;
                    end
                end
                S_SCAN: begin
                    if (w_abort || (w_xfer && w_final)) begin
                        state_q <= w_abort ? S_IDLE : S_DONE;
                        done_q  <= !w_abort;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                    end else if (w_xfer) begin
                        row_q   <= w_row_nxt;
                        col_q   <= w_col_nxt;
                        first_q <= w_first_nxt;
                        last_q  <= w_last_nxt;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.done      = done_q;
    assign bus.first_tap = first_q;
    assign bus.last_tap  = last_q;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.addr      = AW'(32'(row_q) * 32'(IMG_W) + 32'(col_q));
endmodule
`default_nettype wire

// File: tb/tb_conv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_scan_ctrl
// Brief   : Two controller configurations checked against a nested-loop tap model.
// Revision: 1.0
// ============================================================================
module tb_conv_scan_ctrl;

    typedef struct {
        int row;
        int col;
        int addr;
        int first;
        int last;
    } tap_t;

    logic clk;
    logic rst;
    logic r_start;
    logic r_abort;
    logic r_ready;
    logic sel;

    int   n_checks;
    int   n_errors;
    tap_t exp_q[$];

    conv_scan_ctrl_if #(.CW(4), .AW(6)) ifa ();
    conv_scan_ctrl_if #(.CW(4), .AW(6)) ifb ();

    assign ifa.start = r_start && !sel;
    assign ifb.start = r_start && sel;
    assign ifa.abort = r_abort;
    assign ifb.abort = r_abort;
    assign ifa.ready = r_ready;
    assign ifb.ready = r_ready;

    conv_scan_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .CW(4), .AW(6)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    conv_scan_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .CW(4), .AW(6)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    wire       o_busy  = sel ? ifb.busy      : ifa.busy;
    wire       o_valid = sel ? ifb.valid     : ifa.valid;
    wire       o_done  = sel ? ifb.done      : ifa.done;
    wire       o_first = sel ? ifb.first_tap : ifa.first_tap;
    wire       o_last  = sel ? ifb.last_tap  : ifa.last_tap;
    wire [3:0] o_row   = sel ? ifb.row       : ifa.row;
    wire [3:0] o_col   = sel ? ifb.col       : ifa.col;
    wire [5:0] o_addr  = sel ? ifb.addr      : ifa.addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"},  int'(o_busy),  0);
        check_eq({tag, "_valid"}, int'(o_valid), 0);
        check_eq({tag, "_done"},  int'(o_done),  0);
        check_eq({tag, "_first"}, int'(o_first), 0);
        check_eq({tag, "_last"},  int'(o_last),  0);
        check_eq({tag, "_row"},   int'(o_row),   0);
        check_eq({tag, "_col"},   int'(o_col),   0);
        check_eq({tag, "_addr"},  int'(o_addr),  0);
    endtask

    // Expected tap order straight from the window-walk definition.
    task automatic build_model();
        int w, h, k, s, oh, ow;
        tap_t t;
        w = sel ? 5 : 4;
        h = sel ? 5 : 4;
        k = 3;
        s = sel ? 2 : 1;
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        exp_q.delete();
        for (int orow = 0; orow < oh; orow++)
            for (int ocol = 0; ocol < ow; ocol++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        t.row   = orow * s + kr;
                        t.col   = ocol * s + kc;
                        t.addr  = t.row * w + t.col;
                        t.first = (kr == 0 && kc == 0) ? 1 : 0;
                        t.last  = (kr == k - 1 && kc == k - 1) ? 1 : 0;
                        exp_q.push_back(t);
                    end
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall at tap5
    task automatic run_scan(input int mode, input int abort_at, input int restart_at,
                            input int rst_at);
        int   idx;
        int   cyc;
        int   stall;
        int   total;
        tap_t e;
        build_model();
        total = exp_q.size();
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
        check_eq("busy_after_start", int'(o_busy), 1);
        idx = 0;
        cyc = 0;
        stall = 0;
        while (idx < total && cyc < 2000) begin
            e = exp_q[idx];
            check_eq("valid", int'(o_valid), 1);
            check_eq("row",   int'(o_row),   e.row);
            check_eq("col",   int'(o_col),   e.col);
            check_eq("addr",  int'(o_addr),  e.addr);
            check_eq("first", int'(o_first), e.first);
            check_eq("last",  int'(o_last),  e.last);
            check_eq("done_mid", int'(o_done), 0);
            case (mode)
                1:       r_ready = ($urandom % 4) != 0;
                2:       r_ready = !(idx == 4 && stall < 3);
                default: r_ready = 1'b1;
            endcase
            if (!r_ready) stall++;
            if (idx == restart_at) r_start = 1'b1;
            if (idx == abort_at) begin
                r_abort = 1'b1;
                r_ready = 1'b1;
            end
            if (idx == rst_at) rst = 1'b1;
            tick();
            r_start = 1'b0;
            cyc++;
            if (r_abort) begin
                r_abort = 1'b0;
                check_eq("abort_busy",  int'(o_busy),  0);
                check_eq("abort_valid", int'(o_valid), 0);
                for (int i = 0; i < 4; i++) begin
                    check_eq("abort_no_done", int'(o_done), 0);
                    tick();
                end
                return;
            end
            if (rst) begin
                rst = 1'b0;
                check_idle("rst_mid");
                return;
            end
            if (r_ready) idx++;
        end
        if (idx < total) begin
            check_eq("timeout_taps", idx, total);
            return;
        end
        if (mode == 0) check_eq("cycles_no_stall", cyc, total);
        if (mode == 2) check_eq("cycles_stall", cyc, total + 3);
        r_ready = 1'b0;
        check_eq("end_valid", int'(o_valid), 0);
        check_eq("end_busy",  int'(o_busy),  0);
        check_eq("end_done",  int'(o_done),  1);
        tick();
        check_eq("done_pulse_width", int'(o_done), 0);
        check_eq("post_valid", int'(o_valid), 0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        r_start = 1'b0;
        r_abort = 1'b0;
        r_ready = 1'b0;
        sel = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // 4x4 map, K=3, stride 1
        run_scan(0, -1, -1, -1);
        run_scan(2, -1, -1, -1);
        run_scan(0, -1, 6, -1);
        run_scan(1, 19, -1, -1);
        run_scan(0, -1, -1, -1);
        run_scan(1, -1, -1, 14);
        tick();
        check_idle("after_rst");

        rst = 1'b1;
        r_start = 1'b1;
        tick();
        check_idle("rst_with_start");
        tick();
        check_idle("rst_with_start2");
        rst = 1'b0;
        r_start = 1'b0;
        tick();
        check_idle("rst_release");

        // abort while idle is ignored and the next scan is clean
        r_abort = 1'b1;
        tick();
        r_abort = 1'b0;
        check_idle("abort_idle");

        // 5x5 map, K=3, stride 2
        sel = 1'b1;
        tick();
        run_scan(0, -1, -1, -1);
        run_scan(1, -1, -1, -1);

        for (int i = 0; i < 6; i++) begin
            sel = ($urandom % 2) != 0;
            tick();
            run_scan(1, ($urandom % 3 == 0) ? int'($urandom_range(0, 35)) : -1,
                     int'($urandom_range(0, 35)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
